// File: rtl/c_realign_buffer.sv
// c_realign_buffer: halfword realignment buffer between I-cache fetch and RV32IC decode.
// Emits one aligned 16-bit or 32-bit instruction per handshake, including 32-bit
// instructions split across two fetch words, and handles halfword-aligned redirects.
// Optional issue statistics ports (stat_inst_o, stat_straddle_o) are enabled by
// defining C_REALIGN_STATS_EN.
module c_realign_buffer #(
   parameter int unsigned FETCH_W  = 32,
   parameter int unsigned DEPTH_HW = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush_i,
   input  logic [31:0]        flush_pc_i,
   input  logic               fetch_valid_i,
   output logic               fetch_ready_o,
   input  logic [FETCH_W-1:0] fetch_data_i,
   input  logic [31:0]        fetch_pc_i,
   output logic               inst_valid_o,
   input  logic               inst_ready_i,
   output logic [31:0]        inst_o,
   output logic [31:0]        inst_pc_o,
   output logic               inst_is_comp_o,
   output logic               inst_straddle_o
`ifdef C_REALIGN_STATS_EN
   ,
   output logic [31:0]        stat_inst_o,
   output logic [31:0]        stat_straddle_o
`endif
);

   localparam int unsigned NHW  = FETCH_W / 16;
   localparam int unsigned AW   = $clog2(DEPTH_HW);
   localparam int unsigned PW   = AW + 1;
   localparam int unsigned OFFW = $clog2(NHW);
   localparam logic [31:0] WORD_MASK = ~(32'(FETCH_W / 8) - 32'd1);

   typedef enum logic [1:0] {S_ALIGN, S_RUN, S_WAIT_HI} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]     pc_q, pc_d;
   logic            word_tag_q, word_tag_d;
   logic [15:0]     hw_q [DEPTH_HW];
   logic            tag_q [DEPTH_HW];

   logic [PW-1:0]   count, n_push, n_pop;
   logic [OFFW-1:0] push_off;
   logic [AW-1:0]   head0, head1;
   logic            head_comp, head_straddle, push, pop;

   // FIFO occupancy, head decode, push/pop qualification.
   always_comb begin
      count         = wr_ptr_q - rd_ptr_q;
      fetch_ready_o = 32'(count) <= (DEPTH_HW - NHW);
      head0         = rd_ptr_q[AW-1:0];
      head1         = head0 + AW'(1);
      head_comp     = hw_q[head0][1:0] != 2'b11;
      // Halves tagged by different fetch words means the instruction straddled them.
      head_straddle = !head_comp && (tag_q[head0] != tag_q[head1]);
      push_off      = (state_q == S_ALIGN) ? pc_q[OFFW:1] : '0;
      n_push        = PW'(NHW) - PW'(push_off);
      n_pop         = head_comp ? PW'(1) : PW'(2);
      push          = fetch_valid_i && fetch_ready_o && !flush_i &&
                      (state_q != S_ALIGN || fetch_pc_i == (pc_q & WORD_MASK));
      inst_valid_o  = (state_q == S_RUN) &&
                      (head_comp ? (count >= PW'(1)) : (count >= PW'(2)));
      pop           = inst_valid_o && inst_ready_i && !flush_i;
   end

   // Next-state, pointer and PC update; flush overrides any push or pop.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pc_d       = pc_q;
      word_tag_d = word_tag_q;
      unique case (state_q)
         S_ALIGN:   if (push) state_d = S_RUN;
         S_RUN:     if (!head_comp && count == PW'(1) && !push) state_d = S_WAIT_HI;
         S_WAIT_HI: if (push) state_d = S_RUN;
         default:   state_d = S_ALIGN;
      endcase
      if (flush_i) begin
         state_d  = S_ALIGN;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         pc_d     = flush_pc_i & ~32'd1;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + n_push;
            word_tag_d = !word_tag_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + n_pop;
            pc_d     = pc_q + (head_comp ? 32'd2 : 32'd4);
         end
      end
   end

   // Instruction outputs; PC stays visible so reset presents RESET_PC.
   always_comb begin
      inst_o          = '0;
      inst_is_comp_o  = inst_valid_o && head_comp;
      inst_straddle_o = inst_valid_o && head_straddle;
      inst_pc_o       = pc_q;
      if (inst_valid_o)
         inst_o = head_comp ? {16'h0000, hw_q[head0]} : {hw_q[head1], hw_q[head0]};
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_ALIGN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pc_q       <= RESET_PC;
         word_tag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pc_q       <= pc_d;
         word_tag_q <= word_tag_d;
      end
   end

   // Halfword storage; while aligning, halfwords below the target offset are skipped.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         for (int unsigned i = 0; i < NHW; i++) begin
            if (i >= 32'(push_off)) begin
               hw_q[wr_ptr_q[AW-1:0] + AW'(i) - AW'(push_off)]  <= fetch_data_i[16*i +: 16];
               tag_q[wr_ptr_q[AW-1:0] + AW'(i) - AW'(push_off)] <= word_tag_q;
            end
         end
      end
   end

`ifdef C_REALIGN_STATS_EN
   logic [31:0] stat_inst_q, stat_straddle_q;

   // Issue counters; cleared only by reset, never by flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_inst_q     <= '0;
         stat_straddle_q <= '0;
      end else if (pop) begin
         stat_inst_q <= stat_inst_q + 32'd1;
         if (head_straddle) stat_straddle_q <= stat_straddle_q + 32'd1;
      end
   end

   assign stat_inst_o     = stat_inst_q;
   assign stat_straddle_o = stat_straddle_q;
`endif

endmodule

// File: tb/tb_c_realign_buffer.sv
// tb_c_realign_buffer: directed self-checking bench for c_realign_buffer
// (32-bit fetch instance plus a 64-bit fetch instance).
module tb_c_realign_buffer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_flush, a_fv, a_fr, a_ir, a_iv, a_comp, a_strad;
   logic [31:0] a_flush_pc, a_fd, a_fpc, a_inst, a_ipc;
   logic [66:0] a_obs;

   logic        b_flush, b_fv, b_fr, b_ir, b_iv, b_comp, b_strad;
   logic [31:0] b_flush_pc, b_fpc, b_inst, b_ipc;
   logic [63:0] b_fd;
   logic [66:0] b_obs;

   int tests  = 0;
   int failed = 0;

   assign a_obs = {a_iv, a_comp, a_strad, a_inst, a_ipc};
   assign b_obs = {b_iv, b_comp, b_strad, b_inst, b_ipc};

   c_realign_buffer #(.FETCH_W(32), .DEPTH_HW(8), .RESET_PC(32'h0000_0000)) dut32 (
      .clk(clk), .reset(reset), .flush_i(a_flush), .flush_pc_i(a_flush_pc),
      .fetch_valid_i(a_fv), .fetch_ready_o(a_fr), .fetch_data_i(a_fd), .fetch_pc_i(a_fpc),
      .inst_valid_o(a_iv), .inst_ready_i(a_ir), .inst_o(a_inst), .inst_pc_o(a_ipc),
      .inst_is_comp_o(a_comp), .inst_straddle_o(a_strad));

   c_realign_buffer #(.FETCH_W(64), .DEPTH_HW(8), .RESET_PC(32'h0000_0000)) dut64 (
      .clk(clk), .reset(reset), .flush_i(b_flush), .flush_pc_i(b_flush_pc),
      .fetch_valid_i(b_fv), .fetch_ready_o(b_fr), .fetch_data_i(b_fd), .fetch_pc_i(b_fpc),
      .inst_valid_o(b_iv), .inst_ready_i(b_ir), .inst_o(b_inst), .inst_pc_o(b_ipc),
      .inst_is_comp_o(b_comp), .inst_straddle_o(b_strad));

   // Distinct compressed halfword (low bits 01) for index j.
   function automatic logic [15:0] hw_of(int j);
      return 16'(j * 256 + 1);
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      a_flush = 0; a_flush_pc = '0; a_fv = 0; a_fd = '0; a_fpc = '0; a_ir = 0;
      b_flush = 0; b_flush_pc = '0; b_fv = 0; b_fd = '0; b_fpc = '0; b_ir = 0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      @(negedge clk);
      tests++; if (a_obs !== 67'h0) begin failed++; $display("FAIL rst_out32 got %h exp %h", a_obs, 67'h0); end
      tests++; if (a_fr !== 1'b1) begin failed++; $display("FAIL rst_ready32 got %b exp 1", a_fr); end
      tests++; if (b_obs !== 67'h0) begin failed++; $display("FAIL rst_out64 got %h exp %h", b_obs, 67'h0); end
      tests++; if (b_fr !== 1'b1) begin failed++; $display("FAIL rst_ready64 got %b exp 1", b_fr); end
      step();
      a_fv = 1; a_fd = 32'h0000_0013; a_fpc = 32'h0;
      @(negedge clk);
      tests++; if (a_fr !== 1'b1) begin failed++; $display("FAIL first_ready got %b exp 1", a_fr); end
      step();
      a_fv = 0;
      @(negedge clk);
      tests++; if (a_obs !== {3'b100, 32'h0000_0013, 32'h0}) begin failed++; $display("FAIL first_inst got %h exp %h", a_obs, {3'b100, 32'h0000_0013, 32'h0}); end
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      tests++; if (a_obs !== 67'h0) begin failed++; $display("FAIL midrst_out got %h exp %h", a_obs, 67'h0); end
      tests++; if (a_fr !== 1'b1) begin failed++; $display("FAIL midrst_ready got %b exp 1", a_fr); end
   endtask

   task automatic test_straddle;
      do_reset();
      a_ir = 1; a_fv = 1; a_fd = 32'h0513_0001; a_fpc = 32'h0;
      step();
      a_fv = 0;
      @(negedge clk);
      tests++; if (a_obs !== {3'b110, 32'h0000_0001, 32'h0}) begin failed++; $display("FAIL str_cnop got %h exp %h", a_obs, {3'b110, 32'h0000_0001, 32'h0}); end
      step();
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL str_half_wait got %b exp 0", a_iv); end
      step();
      a_fv = 1; a_fd = 32'h0001_4505; a_fpc = 32'h4;
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL str_wait_hi got %b exp 0", a_iv); end
      step();
      a_fv = 0;
      @(negedge clk);
      tests++; if (a_obs !== {3'b101, 32'h4505_0513, 32'h2}) begin failed++; $display("FAIL str_inst got %h exp %h", a_obs, {3'b101, 32'h4505_0513, 32'h2}); end
      step();
      @(negedge clk);
      tests++; if (a_obs !== {3'b110, 32'h0000_0001, 32'h6}) begin failed++; $display("FAIL str_tail got %h exp %h", a_obs, {3'b110, 32'h0000_0001, 32'h6}); end
      step();
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL str_empty got %b exp 0", a_iv); end
   endtask

   task automatic test_flush_align;
      do_reset();
      a_ir = 1; a_flush = 1; a_flush_pc = 32'h0000_0103;
      step();
      a_flush = 0; a_fv = 1; a_fpc = 32'h80; a_fd = 32'h1234_5678;
      @(negedge clk);
      tests++; if (a_iv !== 1'b0 || a_fr !== 1'b1) begin failed++; $display("FAIL fl_align got v=%b r=%b exp v=0 r=1", a_iv, a_fr); end
      step();
      a_fpc = 32'h100; a_fd = 32'h0001_AAAA;
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL fl_stale got %b exp 0", a_iv); end
      step();
      a_fpc = 32'h104; a_fd = 32'h0000_0013;
      @(negedge clk);
      tests++; if (a_obs !== {3'b110, 32'h0000_0001, 32'h102}) begin failed++; $display("FAIL fl_first got %h exp %h", a_obs, {3'b110, 32'h0000_0001, 32'h102}); end
      step();
      a_fv = 0;
      @(negedge clk);
      tests++; if (a_obs !== {3'b100, 32'h0000_0013, 32'h104}) begin failed++; $display("FAIL fl_second got %h exp %h", a_obs, {3'b100, 32'h0000_0013, 32'h104}); end
      step();
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL fl_empty got %b exp 0", a_iv); end
   endtask

   task automatic test_backpressure;
      do_reset();
      a_flush = 1; a_flush_pc = 32'h2;
      step();
      a_flush = 0;
      for (int k = 0; k < 4; k++) begin
         a_fv = 1; a_fpc = 32'(4 * k); a_fd = {hw_of(2 * k + 1), hw_of(2 * k)};
         if (k > 0) begin
            @(negedge clk);
            tests++; if (a_obs !== {3'b110, 16'h0, hw_of(1), 32'h2}) begin failed++; $display("FAIL bp_stable got %h exp %h", a_obs, {3'b110, 16'h0, hw_of(1), 32'h2}); end
         end
         step();
      end
      a_fpc = 32'h10; a_fd = {hw_of(9), hw_of(8)};
      @(negedge clk);
      tests++; if (a_fr !== 1'b0) begin failed++; $display("FAIL bp_full got %b exp 0", a_fr); end
      tests++; if (a_obs !== {3'b110, 16'h0, hw_of(1), 32'h2}) begin failed++; $display("FAIL bp_hold got %h exp %h", a_obs, {3'b110, 16'h0, hw_of(1), 32'h2}); end
      step();
      a_fv = 0; a_ir = 1;
      for (int j = 1; j < 8; j++) begin
         @(negedge clk);
         tests++; if (a_obs !== {3'b110, 16'h0, hw_of(j), 32'(2 * j)}) begin failed++; $display("FAIL bp_drain got %h exp %h", a_obs, {3'b110, 16'h0, hw_of(j), 32'(2 * j)}); end
         if (j == 2) begin
            tests++; if (a_fr !== 1'b1) begin failed++; $display("FAIL bp_reopen got %b exp 1", a_fr); end
         end
         step();
      end
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL bp_empty got %b exp 0", a_iv); end
   endtask

   task automatic test_flush_collision;
      do_reset();
      a_fv = 1; a_fpc = 32'h0; a_fd = 32'h0001_0001;
      step();
      a_fv = 0;
      @(negedge clk);
      tests++; if (a_obs !== {3'b110, 32'h1, 32'h0}) begin failed++; $display("FAIL col_pre got %h exp %h", a_obs, {3'b110, 32'h1, 32'h0}); end
      step();
      a_flush = 1; a_flush_pc = 32'h40; a_fv = 1; a_fpc = 32'h40; a_fd = 32'h0005_0005; a_ir = 1;
      @(negedge clk);
      tests++; if (a_fr !== 1'b1) begin failed++; $display("FAIL col_ready got %b exp 1", a_fr); end
      step();
      a_flush = 0; a_fv = 0;
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL col_valid got %b exp 0", a_iv); end
      step();
      a_fv = 1; a_fpc = 32'h40; a_fd = 32'h0009_0001;
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL col_align got %b exp 0", a_iv); end
      step();
      a_fv = 0;
      @(negedge clk);
      tests++; if (a_obs !== {3'b110, 32'h1, 32'h40}) begin failed++; $display("FAIL col_first got %h exp %h", a_obs, {3'b110, 32'h1, 32'h40}); end
      step();
      @(negedge clk);
      tests++; if (a_obs !== {3'b110, 32'h9, 32'h42}) begin failed++; $display("FAIL col_second got %h exp %h", a_obs, {3'b110, 32'h9, 32'h42}); end
      step();
      @(negedge clk);
      tests++; if (a_iv !== 1'b0) begin failed++; $display("FAIL col_empty got %b exp 0", a_iv); end
   endtask

   task automatic test_fetch64;
      logic [15:0] h;
      logic [31:0] pc;
      do_reset();
      b_ir = 1; b_flush = 1; b_flush_pc = 32'h1006;
      step();
      b_flush = 0; b_fv = 1; b_fpc = 32'h1000; b_fd = 64'h0031_0021_0011_0001;
      step();
      b_fv = 0;
      @(negedge clk);
      tests++; if (b_obs !== {3'b110, 32'h31, 32'h1006}) begin failed++; $display("FAIL w64_hw3 got %h exp %h", b_obs, {3'b110, 32'h31, 32'h1006}); end
      step();
      @(negedge clk);
      tests++; if (b_iv !== 1'b0) begin failed++; $display("FAIL w64_only_hw3 got %b exp 0", b_iv); end
      for (int k = 0; k < 20; k++) begin
         b_fv = 1; b_fpc = 32'(32'h1008 + 8 * k);
         for (int i = 0; i < 4; i++) b_fd[16*i +: 16] = 16'(((k * 4 + i) << 2) | 1);
         step();
         b_fv = 0;
         for (int i = 0; i < 4; i++) begin
            h  = 16'(((k * 4 + i) << 2) | 1);
            pc = 32'(32'h1008 + 8 * k + 2 * i);
            @(negedge clk);
            tests++; if (b_obs !== {3'b110, 16'h0, h, pc}) begin failed++; $display("FAIL w64_wrap got %h exp %h", b_obs, {3'b110, 16'h0, h, pc}); end
            step();
         end
      end
      @(negedge clk);
      tests++; if (b_iv !== 1'b0) begin failed++; $display("FAIL w64_empty got %b exp 0", b_iv); end
   endtask

   initial begin
      test_reset();
      test_straddle();
      test_flush_align();
      test_backpressure();
      test_flush_collision();
      test_fetch64();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
